// File: rtl/udp_tx_framer.sv
// Ethernet/IPv4/UDP transmit framer: wraps a raw byte stream into fixed-length
// frames (42-byte generated header + PAYLOAD_LEN payload bytes) for a MAC TX stream.
module udp_tx_framer #(
  parameter int unsigned PAYLOAD_LEN = 1024,
  parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
  parameter logic [15:0] SRC_PORT    = 16'd5000,
  parameter logic [7:0]  TTL         = 8'h40
) (
  input  logic        tx_clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic [47:0] dst_mac,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  input  logic [15:0] dst_port,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic [15:0] frame_count,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: a byte moves on a tx_clk edge where valid & ready are both high;
  // a source holding valid keeps data stable until that edge.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CSUM    = 2'd1,
    HEADER  = 2'd2,
    PAYLOAD = 2'd3
  } state_t;

  localparam logic [15:0] TOTAL_LEN = 16'(28 + PAYLOAD_LEN);
  localparam logic [15:0] UDP_LEN   = 16'(8 + PAYLOAD_LEN);
  localparam logic [15:0] LAST_IDX  = 16'(PAYLOAD_LEN - 1);
  localparam logic [3:0]  CSUM_LAST = 4'd9;
  localparam logic [5:0]  HDR_LAST  = 6'd41;

  state_t        state;
  state_t        state_n;
  logic [3:0]    csum_idx;
  logic [5:0]    hdr_idx;
  logic [15:0]   pay_cnt;
  logic [16:0]   acc;
  logic [16:0]   acc_sum;
  logic [16:0]   acc_n;
  logic [15:0]   csum_word;
  logic [15:0]   hdr_csum;
  logic [15:0]   ip_ident;
  logic [47:0]   dst_mac_q;
  logic [31:0]   src_ip_q;
  logic [31:0]   dst_ip_q;
  logic [15:0]   dst_port_q;
  logic [335:0]  hdr_vec;
  logic [8:0]    hdr_bit;
  logic [7:0]    hdr_byte;
  logic          start;
  logic          hdr_fire;
  logic          pay_fire;
  logic          pay_last;

  // Words of the IPv4 header, checksum field taken as zero.
  always_comb begin
    csum_word = 16'h0000;
    case (csum_idx)
      4'd0: csum_word = 16'h4500;
      4'd1: csum_word = TOTAL_LEN;
      4'd2: csum_word = ip_ident;
      4'd3: csum_word = 16'h4000;
      4'd4: csum_word = {TTL, 8'h11};
      4'd5: csum_word = 16'h0000;
      4'd6: csum_word = src_ip_q[31:16];
      4'd7: csum_word = src_ip_q[15:0];
      4'd8: csum_word = dst_ip_q[31:16];
      4'd9: csum_word = dst_ip_q[15:0];
      default: csum_word = 16'h0000;
    endcase
  end

  // End-around carry folded back into bit 0 every cycle keeps acc[16] clear.
  assign acc_sum = acc + {1'b0, csum_word};
  assign acc_n   = {1'b0, acc_sum[15:0]} + {16'd0, acc_sum[16]};

  assign hdr_vec = {dst_mac_q, SRC_MAC, 16'h0800, 16'h4500, TOTAL_LEN, ip_ident,
                    16'h4000, TTL, 8'h11, hdr_csum, src_ip_q, dst_ip_q,
                    SRC_PORT, dst_port_q, UDP_LEN, 16'h0000};
  assign hdr_bit  = {HDR_LAST - hdr_idx, 3'b000};
  assign hdr_byte = hdr_vec[hdr_bit +: 8];

  assign pay_last = (pay_cnt == LAST_IDX);
  assign m_tuser  = 1'b0;
  assign busy     = (state != IDLE);
  assign dbg_state = state;

  always_comb begin
    state_n  = state;
    s_tready = 1'b0;
    m_tvalid = 1'b0;
    m_tdata  = 8'h00;
    m_tlast  = 1'b0;
    start    = 1'b0;
    hdr_fire = 1'b0;
    pay_fire = 1'b0;
    case (state)
      IDLE: begin
        if (enable && s_tvalid) begin
          start   = 1'b1;
          state_n = CSUM;
        end
      end
      CSUM: begin
        if (csum_idx == CSUM_LAST) state_n = HEADER;
      end
      HEADER: begin
        m_tvalid = 1'b1;
        m_tdata  = hdr_byte;
        hdr_fire = m_tready;
        if (m_tready && hdr_idx == HDR_LAST) state_n = PAYLOAD;
      end
      PAYLOAD: begin
        m_tvalid = s_tvalid;
        m_tdata  = s_tdata;
        s_tready = m_tready;
        m_tlast  = pay_last;
        pay_fire = s_tvalid && m_tready;
        if (s_tvalid && m_tready && pay_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge tx_clk or negedge rstn) begin
    if (!rstn) begin
      csum_idx    <= 4'd0;
      hdr_idx     <= 6'd0;
      pay_cnt     <= 16'd0;
      acc         <= 17'd0;
      hdr_csum    <= 16'd0;
      ip_ident    <= 16'd0;
      frame_count <= 16'd0;
      dst_mac_q   <= 48'd0;
      src_ip_q    <= 32'd0;
      dst_ip_q    <= 32'd0;
      dst_port_q  <= 16'd0;
    end else begin
      if (start) begin
        dst_mac_q  <= dst_mac;
        src_ip_q   <= src_ip;
        dst_ip_q   <= dst_ip;
        dst_port_q <= dst_port;
        acc        <= 17'd0;
        csum_idx   <= 4'd0;
      end
      if (state == CSUM) begin
        acc      <= acc_n;
        csum_idx <= csum_idx + 4'd1;
        if (csum_idx == CSUM_LAST) begin
          hdr_csum <= ~acc_n[15:0];
          hdr_idx  <= 6'd0;
          pay_cnt  <= 16'd0;
        end
      end
      if (hdr_fire) hdr_idx <= hdr_idx + 6'd1;
      if (pay_fire) begin
        pay_cnt <= pay_cnt + 16'd1;
        if (pay_last) begin
          frame_count <= frame_count + 16'd1;
          ip_ident    <= ip_ident + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_udp_tx_framer.sv
// Randomized scoreboard bench for udp_tx_framer: a frame-level reference model
// queues expected bytes; a negedge monitor pops and compares every transfer.
module tb_udp_tx_framer;

  localparam int          PL       = 64;
  localparam logic [47:0] SRC_MAC  = 48'h02_00_00_00_00_01;
  localparam logic [15:0] SRC_PORT = 16'd5000;
  localparam logic [7:0]  TTL      = 8'h40;

  logic        tx_clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [47:0] dst_mac;
  logic [31:0] src_ip;
  logic [31:0] dst_ip;
  logic [15:0] dst_port;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        m_tuser;
  logic [15:0] frame_count;
  logic        busy;
  logic [1:0]  dbg_state;

  udp_tx_framer #(.PAYLOAD_LEN(PL)) dut (
    .tx_clk(tx_clk), .rstn(rstn), .enable(enable), .dst_mac(dst_mac),
    .src_ip(src_ip), .dst_ip(dst_ip), .dst_port(dst_port),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .frame_count(frame_count),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 tx_clk = ~tx_clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [8:0]  exp_q[$];
  logic [7:0]  mon_frame[$];
  logic [7:0]  last_frame[$];
  logic [7:0]  pay[PL];
  logic [15:0] model_ident = 16'd0;
  logic [15:0] model_count = 16'd0;
  logic        hold_q = 1'b0;
  logic [7:0]  hold_data = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge tx_clk) begin
    if (!rstn) begin
      hold_q = 1'b0;
      mon_frame.delete();
    end else begin
      if (hold_q) begin
        check("hold_tvalid", 64'(m_tvalid), 64'd1);
        check("hold_tdata", 64'(m_tdata), 64'(hold_data));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_byte: got %h with no byte expected at %0t", m_tdata, $time);
        end else begin
          check("frame_byte", 64'({m_tlast, m_tdata}), 64'(exp_q.pop_front()));
        end
        check("tuser", 64'(m_tuser), 64'd0);
        mon_frame.push_back(m_tdata);
        if (m_tlast) begin
          last_frame = mon_frame;
          mon_frame.delete();
        end
      end
      hold_q    = m_tvalid && !m_tready;
      hold_data = m_tdata;
    end
  end

  task automatic push_be(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back({1'b0, v[8*i +: 8]});
  endtask

  // Reference model: whole frame from the protocol rules.
  task automatic push_frame(input logic [47:0] dm, input logic [31:0] sip,
                            input logic [31:0] dip, input logic [15:0] dp,
                            input logic [15:0] id);
    int unsigned sum;
    logic [15:0] csum;
    logic [15:0] tot;
    tot = 16'(28 + PL);
    sum = 32'h4500 + 32'(tot) + 32'(id) + 32'h4000 + 32'({TTL, 8'h11})
        + 32'(sip[31:16]) + 32'(sip[15:0]) + 32'(dip[31:16]) + 32'(dip[15:0]);
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    csum = ~sum[15:0];
    push_be(64'(dm), 6);
    push_be(64'(SRC_MAC), 6);
    push_be(64'h0800, 2);
    push_be(64'h4500, 2);
    push_be(64'(tot), 2);
    push_be(64'(id), 2);
    push_be(64'h4000, 2);
    push_be(64'({TTL, 8'h11}), 2);
    push_be(64'(csum), 2);
    push_be(64'(sip), 4);
    push_be(64'(dip), 4);
    push_be(64'(SRC_PORT), 2);
    push_be(64'(dp), 2);
    push_be(64'(8 + PL), 2);
    push_be(64'h0000, 2);
    for (int i = 0; i < PL; i++) exp_q.push_back({1'(i == PL - 1), pay[i]});
  endtask

  // driver: one frame, optional stalls, upstream gap, mid-payload reset, enable drop
  task automatic run_frame(input logic [47:0] dm, input logic [31:0] sip,
                           input logic [31:0] dip, input logic [15:0] dp,
                           input bit stall, input bit gap, input int rst_at,
                           input bit drop_en);
    int p;
    int gap_left;
    int cyc;
    bit done;
    bit in_gap;
    for (int i = 0; i < PL; i++) pay[i] = 8'($urandom);
    push_frame(dm, sip, dip, dp, model_ident);
    dst_mac = dm; src_ip = sip; dst_ip = dip; dst_port = dp;
    enable = 1'b1; s_tvalid = 1'b1; s_tdata = pay[0];
    p = 0; gap_left = 5; cyc = 0; done = 1'b0;
    while (!done && cyc < 4000) begin
      m_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (gap && p == 10 && gap_left > 0) begin
        s_tvalid = 1'b0; gap_left--; in_gap = 1'b1;
      end else begin
        s_tvalid = 1'b1; in_gap = 1'b0;
      end
      if (drop_en && busy) enable = 1'b0;
      @(negedge tx_clk);
      if (in_gap) check("gap_tvalid", 64'(m_tvalid), 64'd0);
      if (rst_at >= 0 && p == rst_at) begin
        #2 rstn = 1'b0;
        #1 check("async_reset_outputs",
                 64'({s_tready, m_tvalid, m_tlast, m_tuser, busy, m_tdata, frame_count}), 64'd0);
        enable = 1'b0; s_tvalid = 1'b0;
        exp_q.delete();
        model_ident = 16'd0;
        model_count = 16'd0;
        repeat (2) @(negedge tx_clk);
        #2 rstn = 1'b1;
        @(posedge tx_clk); #1;
        return;
      end
      if (s_tvalid && s_tready) begin
        if (m_tlast) done = 1'b1;
        p++;
      end
      @(posedge tx_clk); #1;
      if (p < PL) s_tdata = pay[p];
      cyc++;
    end
    s_tvalid = 1'b0;
    enable   = 1'b0;
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL frame_timeout: got %0d payload bytes expected %0d", p, PL);
    end
    model_ident = model_ident + 16'd1;
    model_count = model_count + 16'd1;
    check("payload_bytes", 64'(p), 64'(PL));
    check("frame_count", 64'(frame_count), 64'(model_count));
    repeat (3) @(posedge tx_clk);
    #1;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish expected finish before 800000");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; enable = 1'b0; s_tvalid = 1'b0; s_tdata = 8'h00; m_tready = 1'b0;
    dst_mac = '0; src_ip = '0; dst_ip = '0; dst_port = '0;
    repeat (3) @(negedge tx_clk);
    check("reset_outputs",
          64'({s_tready, m_tvalid, m_tlast, m_tuser, busy, m_tdata, frame_count}), 64'd0);
    #2 rstn = 1'b1;
    @(posedge tx_clk); #1;

    // enable gating: data offered while disabled starts nothing
    enable = 1'b0; s_tvalid = 1'b1; m_tready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge tx_clk);
      check("gate_idle", 64'({s_tready, m_tvalid, busy}), 64'd0);
    end
    @(posedge tx_clk); #1;
    s_tvalid = 1'b0;

    // abort mid-payload; the follow-up frame reuses ident 0
    run_frame(48'h11_22_33_44_55_66, 32'hC0A8010A, 32'hC0A80101, 16'd7000, 1'b0, 1'b0, 20, 1'b0);

    // reference checksum frame
    run_frame(48'hFF_FF_FF_FF_FF_FF, 32'hC0A8010A, 32'hC0A80101, 16'd6000, 1'b0, 1'b0, -1, 1'b0);
    check("frame_len", 64'(last_frame.size()), 64'd106);
    if (last_frame.size() == 106) begin
      check("total_len_hi", 64'(last_frame[16]), 64'h00);
      check("total_len_lo", 64'(last_frame[17]), 64'h5C);
      check("ident_hi", 64'(last_frame[18]), 64'h00);
      check("csum_hi", 64'(last_frame[24]), 64'hB7);
      check("csum_lo", 64'(last_frame[25]), 64'h35);
      check("udp_len_hi", 64'(last_frame[38]), 64'h00);
      check("udp_len_lo", 64'(last_frame[39]), 64'h48);
    end

    // random backpressure
    for (int k = 0; k < 3; k++)
      run_frame({$urandom, $urandom} & 48'hFFFF_FFFF_FFFF, $urandom, $urandom,
                16'($urandom), 1'b1, 1'b0, -1, 1'b0);

    // upstream gap at payload byte 10
    run_frame(48'h00_1B_21_AA_BB_CC, $urandom, $urandom, 16'($urandom), 1'b0, 1'b1, -1, 1'b0);

    // enable dropped mid-frame: frame completes, nothing new starts
    run_frame(48'h00_1B_21_01_02_03, $urandom, $urandom, 16'($urandom), 1'b1, 1'b0, -1, 1'b1);
    s_tvalid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge tx_clk);
      check("post_drop_idle", 64'({s_tready, m_tvalid, busy}), 64'd0);
    end
    @(posedge tx_clk); #1;
    s_tvalid = 1'b0;

    // ident wrap
    force dut.ip_ident = 16'hFFFF;
    @(posedge tx_clk); #1;
    release dut.ip_ident;
    model_ident = 16'hFFFF;
    run_frame(48'h00_AA_00_BB_00_CC, 32'h0A000001, 32'h0A0000FE, 16'd1234, 1'b1, 1'b0, -1, 1'b0);
    check("wrap_ident_a", 64'({last_frame[18], last_frame[19]}), 64'hFFFF);
    run_frame(48'h00_AA_00_BB_00_CC, 32'h0A000001, 32'h0A0000FE, 16'd1234, 1'b0, 1'b0, -1, 1'b0);
    check("wrap_ident_b", 64'({last_frame[18], last_frame[19]}), 64'h0000);

    repeat (5) @(posedge tx_clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
